// File: rtl/fb_arbiter.sv
// Frame-buffer access controller: scan-out reads on every active pixel tick,
// round-robin draw-port writes otherwise. Optional macro: FB_VBLANK_WRITE_EN.
module fb_arbiter #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              wr_req0,
    input  logic              wr_req1,
    input  logic [9:0]        wr_x0,
    input  logic [9:0]        wr_y0,
    input  logic [9:0]        wr_x1,
    input  logic [9:0]        wr_y1,
    input  logic [DATA_W-1:0] wr_color0,
    input  logic [DATA_W-1:0] wr_color1,
    output logic              wr_ack0,
    output logic              wr_ack1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] pix_rgb,
    output logic [1:0]        slot_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        WRITE0 = 2'd2,
        WRITE1 = 2'd3
    } slot_t;

    slot_t             state, state_nxt;
    logic              last_grant, last_grant_nxt;
    logic              scan, write_slot, elig0, elig1, grant0, grant1, in_range;
    logic [9:0]        sel_x, sel_y;
    logic [DATA_W-1:0] sel_color;
    logic [ADDR_W-1:0] addr_nxt;
    logic              we_nxt;
    logic              scan_d1, vid_d1, vid_d2;

    assign slot_state = state;

    // y*640 + x as shifts on a 19-bit intermediate, then fitted to the RAM bus.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] x, input logic [9:0] y);
        logic [18:0] a;
        a = ({9'd0, y} << 9) + ({9'd0, y} << 7) + {9'd0, x};
        return ADDR_W'(a);
    endfunction

    // Draw-port handshake: wr_req is a valid held with stable x/y/colour until
    // wr_ack (a one-clock registered ready) is seen; a port is not eligible in
    // its own ack cycle, so a request held through the ack is never taken twice.
    always_comb begin
        state_nxt      = IDLE;
        last_grant_nxt = last_grant;
        grant0         = 1'b0;
        grant1         = 1'b0;
        scan           = p_tick & video_on;
`ifdef FB_VBLANK_WRITE_EN
        write_slot     = ~scan & (pixel_y >= 10'd480);
`else
        write_slot     = ~scan;
`endif
        elig0          = wr_req0 & ~wr_ack0;
        elig1          = wr_req1 & ~wr_ack1;

        if (scan) begin
            state_nxt = SCAN;
        end else if (write_slot && (elig0 || elig1)) begin
            if (elig0 && elig1) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
            state_nxt      = grant1 ? WRITE1 : WRITE0;
            last_grant_nxt = ~last_grant;
        end

        sel_x     = grant1 ? wr_x1 : wr_x0;
        sel_y     = grant1 ? wr_y1 : wr_y0;
        sel_color = grant1 ? wr_color1 : wr_color0;
        in_range  = (sel_x < 10'd640) && (sel_y < 10'd480);
        addr_nxt  = scan ? lin_addr(pixel_x, pixel_y) : lin_addr(sel_x, sel_y);
        we_nxt    = (grant0 | grant1) & in_range;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wr_ack0    <= 1'b0;
            wr_ack1    <= 1'b0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            scan_d1    <= 1'b0;
            vid_d1     <= 1'b0;
            vid_d2     <= 1'b0;
            pix_rgb    <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wr_ack0    <= grant0;
            wr_ack1    <= grant1;
            ram_we     <= we_nxt;
            if (state_nxt != IDLE) begin
                ram_addr <= addr_nxt;
            end
            if (we_nxt) begin
                ram_wdata <= sel_color;
            end
            // Scan return: address out at N+1, data back at N+2, pixel at N+3.
            scan_d1 <= (state == SCAN);
            vid_d1  <= video_on;
            vid_d2  <= vid_d1;
            if (!vid_d2) begin
                pix_rgb <= '0;
            end else if (scan_d1) begin
                pix_rgb <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed cases with literal expectations
// plus a randomized run checked every cycle against a behavioural model.
module tb_fb_arbiter;
  localparam int DATA_W = 3;
  localparam int ADDR_W = 19;
  localparam int W      = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              p_tick = 1'b0;
  logic              video_on = 1'b0;
  logic [9:0]        pixel_x = '0, pixel_y = '0;
  logic              wr_req0 = 1'b0, wr_req1 = 1'b0;
  logic [9:0]        wr_x0 = '0, wr_y0 = '0, wr_x1 = '0, wr_y1 = '0;
  logic [DATA_W-1:0] wr_color0 = '0, wr_color1 = '0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              wr_ack0, wr_ack1, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, pix_rgb;
  logic [1:0]        slot_state;

  fb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_req0(wr_req0), .wr_req1(wr_req1),
    .wr_x0(wr_x0), .wr_y0(wr_y0), .wr_x1(wr_x1), .wr_y1(wr_y1),
    .wr_color0(wr_color0), .wr_color1(wr_color1),
    .wr_ack0(wr_ack0), .wr_ack1(wr_ack1),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .rd_data(rd_data), .pix_rgb(pix_rgb), .slot_state(slot_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // behavioural model state: what the outputs must be after the last edge
  int  m_addr, m_wdata, m_pix, m_last;
  bit  m_av, m_we, m_ack0, m_ack1;
  bit  h_scan[2];
  bit  h_vid[2];
  logic [W-1:0] exp_q[$];
  bit  pa0, pa1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lin(input int x, input int y);
    return (y * 640 + x) & 32'h7FFFF;
  endfunction

  task automatic model_reset();
    m_addr = 0; m_wdata = 0; m_pix = 0; m_last = 1;
    m_av = 1'b1; m_we = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0;
    h_scan[0] = 0; h_scan[1] = 0; h_vid[0] = 0; h_vid[1] = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Compute next outputs from current inputs, clock once, then compare.
  task automatic step();
    int g, sx, sy, sc, n_addr, n_wdata, n_pix, n_last;
    bit scan, slot_ok, e0, e1, n_av, n_we, cur_vid;
    logic [31:0] a32;
    logic [W-1:0] e;
    scan = p_tick && video_on;
    slot_ok = !scan;
`ifdef FB_VBLANK_WRITE_EN
    slot_ok = slot_ok && (pixel_y >= 480);
`endif
    e0 = wr_req0 && !m_ack0;
    e1 = wr_req1 && !m_ack1;
    g = -1;
    if (slot_ok) begin
      if (e0 && e1) g = 1 - m_last;
      else if (e0) g = 0;
      else if (e1) g = 1;
    end
    n_last = (g >= 0) ? 1 - m_last : m_last;
    n_av = 1'b0; n_we = 1'b0; n_addr = m_addr; n_wdata = m_wdata;
    if (scan) begin
      n_addr = lin(pixel_x, pixel_y);
      n_av = 1'b1;
    end else if (g >= 0) begin
      sx = (g == 1) ? wr_x1 : wr_x0;
      sy = (g == 1) ? wr_y1 : wr_y0;
      sc = (g == 1) ? wr_color1 : wr_color0;
      if (sx < 640 && sy < 480) begin
        n_we = 1'b1; n_av = 1'b1;
        n_addr = lin(sx, sy); n_wdata = sc;
        a32 = n_addr;
        e = {a32[ADDR_W-1:0], wr_color_of(g)};
        exp_q.push_back(e);
      end
    end
    n_pix = !h_vid[1] ? 0 : (h_scan[1] ? int'(rd_data) : m_pix);
    cur_vid = video_on;
    @(posedge clk);
    #1;
    h_scan[1] = h_scan[0]; h_scan[0] = scan;
    h_vid[1] = h_vid[0];   h_vid[0] = cur_vid;
    m_addr = n_addr; m_av = n_av; m_we = n_we; m_wdata = n_wdata;
    m_ack0 = (g == 0); m_ack1 = (g == 1); m_pix = n_pix; m_last = n_last;
    // compare process
    check("ram_we", ram_we, m_we);
    check("wr_ack0", wr_ack0, m_ack0);
    check("wr_ack1", wr_ack1, m_ack1);
    check("pix_rgb", pix_rgb, m_pix);
    if (m_av) check("ram_addr", ram_addr, m_addr);
    if (m_we) check("ram_wdata", ram_wdata, m_wdata);
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_queue actual=unexpected_write required=none at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("wr_queue", {ram_addr, ram_wdata}, e);
      end
    end
  endtask

  function automatic logic [DATA_W-1:0] wr_color_of(input int g);
    return (g == 1) ? wr_color1 : wr_color0;
  endfunction

  // driver task for the randomized phase
  task automatic drive_random();
    p_tick = ~p_tick;
    if ($urandom_range(0, 19) == 0) video_on = ~video_on;
    if (video_on) begin
      pixel_x = 10'($urandom_range(0, 639));
      pixel_y = 10'($urandom_range(0, 479));
    end else begin
      pixel_x = 10'($urandom_range(0, 799));
      pixel_y = 10'($urandom_range(0, 524));
    end
    rd_data = DATA_W'($urandom_range(0, 7));
    if (!m_ack0) begin
      if (pa0 || !wr_req0) begin
        wr_req0 = 1'($urandom_range(0, 1));
        wr_x0 = 10'($urandom_range(0, 700));
        wr_y0 = 10'($urandom_range(0, 520));
        wr_color0 = DATA_W'($urandom_range(0, 7));
      end else if ($urandom_range(0, 15) == 0) begin
        wr_req0 = 1'b0;
      end
    end
    if (!m_ack1) begin
      if (pa1 || !wr_req1) begin
        wr_req1 = 1'($urandom_range(0, 1));
        wr_x1 = 10'($urandom_range(0, 700));
        wr_y1 = 10'($urandom_range(0, 520));
        wr_color1 = DATA_W'($urandom_range(0, 7));
      end else if ($urandom_range(0, 15) == 0) begin
        wr_req1 = 1'b0;
      end
    end
    pa0 = m_ack0;
    pa1 = m_ack1;
  endtask

  initial begin
    do_reset();
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_wr_ack0", wr_ack0, 0);
    check("rst_wr_ack1", wr_ack1, 0);
    check("rst_pix_rgb", pix_rgb, 0);

    // scan read
    video_on = 1; p_tick = 1; pixel_x = 5; pixel_y = 2;
    step();
    check("scan_addr", ram_addr, 1285);
    check("scan_we", ram_we, 0);
    p_tick = 0;
    step();
    rd_data = 3'b101;
    step();
    check("scan_pix", pix_rgb, 3'b101);

    // reset mid-write, pixel held from the scan above
    pixel_y = 480;
    wr_req0 = 1; wr_x0 = 1; wr_y0 = 1; wr_color0 = 3'd2;
    step();
    check("mid_we", ram_we, 1);
    check("mid_pix_held", pix_rgb, 3'b101);
    reset_n = 1'b0;
    #1;
    check("mid_rst_we", ram_we, 0);
    check("mid_rst_ack0", wr_ack0, 0);
    check("mid_rst_pix", pix_rgb, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    check("reissue_ack0", wr_ack0, 1);
    check("reissue_addr", ram_addr, 641);
    step();
    check("reissue_once", ram_we, 0);
    wr_req0 = 0; video_on = 0;
    step();

    // single write in blanking
    wr_req0 = 1; wr_x0 = 639; wr_y0 = 479; wr_color0 = 3'b011;
    step();
    check("single_ack0", wr_ack0, 1);
    check("single_we", ram_we, 1);
    check("single_addr", ram_addr, 307199);
    check("single_wdata", ram_wdata, 3'b011);
    step();
    check("single_no_dup_we", ram_we, 0);
    check("single_no_dup_ack", wr_ack0, 0);
    wr_req0 = 0;
    step();

    // contention after reset: 0,1,0,1
    do_reset();
    wr_req0 = 1; wr_x0 = 10; wr_y0 = 20; wr_color0 = 3'd1;
    wr_req1 = 1; wr_x1 = 30; wr_y1 = 40; wr_color1 = 3'd6;
    for (int i = 0; i < 4; i++) begin
      p_tick = ~p_tick;
      step();
      check("cont_ack0", wr_ack0, (i % 2 == 0));
      check("cont_ack1", wr_ack1, (i % 2 == 1));
    end
    wr_req0 = 0; wr_req1 = 0;
    step();

    // clipping
    wr_req1 = 1; wr_x1 = 640; wr_y1 = 10; wr_color1 = 3'd7;
    step();
    check("clip_ack1", wr_ack1, 1);
    check("clip_we", ram_we, 0);
    wr_req1 = 0;
    step();

    // scan priority
`ifdef FB_VBLANK_WRITE_EN
    video_on = 1; p_tick = 1; pixel_x = 3; pixel_y = 100;
    wr_req0 = 1; wr_x0 = 10; wr_y0 = 10; wr_color0 = 3'd6;
    step();
    check("prio_scan_addr", ram_addr, 64003);
    p_tick = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("prio_vblank_wait", wr_ack0, 0);
    end
    pixel_y = 480; video_on = 0;
    step();
    check("prio_vblank_ack0", wr_ack0, 1);
`else
    video_on = 1; p_tick = 1; pixel_x = 3; pixel_y = 0;
    wr_req0 = 1; wr_x0 = 10; wr_y0 = 10; wr_color0 = 3'd6;
    step();
    check("prio_scan_addr", ram_addr, 3);
    check("prio_scan_ack0", wr_ack0, 0);
    p_tick = 0;
    step();
    check("prio_wr_ack0", wr_ack0, 1);
    check("prio_wr_addr", ram_addr, 6410);
`endif
    wr_req0 = 0; video_on = 0;
    step();

    // randomized phase
    pa0 = 0; pa1 = 0;
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      step();
    end
    check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
